// File: rtl/fir_sample_fifo.sv
// Output FIFO for a pipelined FIR filter: delays the input strobe by LATENCY cycles to write aligned samples.
// Optional macro FIR_SAMPLE_FIFO_OVF_CNT_EN adds a saturating 16-bit dropped-sample counter (o_ovf_cnt).
module fir_sample_fifo #(
    parameter int WW_DATA = 8,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      i_srst,
    input  logic                      i_en,
    input  logic signed [WW_DATA-1:0] i_data,
    input  logic                      i_ready,
    input  logic                      i_clr_ovf,
    output logic signed [WW_DATA-1:0] o_data,
    output logic                      o_valid,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full,
    output logic                      o_empty,
    output logic                      o_overflow
`ifdef FIR_SAMPLE_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]               o_ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0]        en_dly;
    logic [WW_DATA-1:0]        mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic                      ovf;
    logic                      wr;
    logic                      pop;
    logic                      do_wr;
    logic                      drop;

    // Handshake: o_valid/i_ready transfer the head sample on any edge where both are high;
    // o_valid never depends on i_ready, and o_data holds until that transfer happens.
    assign wr    = en_dly[LATENCY-1];
    assign pop   = o_valid && i_ready;
    // A pop on the same edge frees the slot the write needs, so a full FIFO still accepts.
    assign do_wr = wr && (!o_full || pop);
    assign drop  = wr && o_full && !pop;

    assign o_full     = (count == CW'(DEPTH));
    assign o_empty    = (count == '0);
    assign o_valid    = !o_empty;
    assign o_count    = count;
    assign o_data     = mem[rd_ptr];
    assign o_overflow = ovf;

    always_ff @(posedge clk or posedge i_srst) begin
        if (i_srst) begin
            en_dly <= '0;
        end else begin
            en_dly <= (en_dly << 1) | LATENCY'(i_en);
        end
    end

    // Sample storage carries no reset; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge i_srst) begin
        if (i_srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_srst) begin
        if (i_srst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef FIR_SAMPLE_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt;

    assign o_ovf_cnt = ovf_cnt;

    always_ff @(posedge clk or posedge i_srst) begin
        if (i_srst) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            if (i_clr_ovf) begin
                ovf_cnt <= 16'd1;
            end else if (ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end else if (i_clr_ovf) begin
            ovf_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Self-checking bench for fir_sample_fifo: per-cycle reference model with an expected-sample queue.
// Define FIR_SAMPLE_FIFO_OVF_CNT_EN for both files to also exercise o_ovf_cnt.
module tb_fir_sample_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int LAT   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_srst;
    logic          i_en;
    logic [W-1:0]  i_data;
    logic          i_ready;
    logic          i_clr_ovf;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
`ifdef FIR_SAMPLE_FIFO_OVF_CNT_EN
    logic [15:0]   o_ovf_cnt;
`endif

    fir_sample_fifo #(.WW_DATA(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .i_srst     (i_srst),
        .i_en       (i_en),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .i_clr_ovf  (i_clr_ovf),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow)
`ifdef FIR_SAMPLE_FIFO_OVF_CNT_EN
        ,
        .o_ovf_cnt  (o_ovf_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic         pend_en [LAT];
    logic [W-1:0] pend_d  [LAT];
    logic         ovf_m;
    int           ovf_cnt_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) begin
            pend_en[i] = 1'b0;
            pend_d[i]  = '0;
        end
        ovf_m     = 1'b0;
        ovf_cnt_m = 0;
    endtask

    // Called at a falling edge; asserts reset asynchronously and releases it one edge later.
    task automatic do_reset();
        i_srst    = 1'b1;
        i_en      = 1'b0;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        #1;
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        i_srst = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, compare, update the model, end at the next falling edge.
    task automatic cycle(input logic en, input logic [W-1:0] d, input logic rdy, input logic clr);
        logic wr, pop, full_m, drop;
        wr        = pend_en[LAT-1];
        i_en      = en;
        i_ready   = rdy;
        i_clr_ovf = clr;
        i_data    = wr ? pend_d[LAT-1] : W'($urandom);
        #1;
        check("count", 32'(o_count), 32'(exp_q.size()));
        check("valid", 32'(o_valid), 32'(exp_q.size() != 0));
        check("empty", 32'(o_empty), 32'(exp_q.size() == 0));
        check("full", 32'(o_full), 32'(exp_q.size() == DEPTH));
        check("ovf", 32'(o_overflow), 32'(ovf_m));
`ifdef FIR_SAMPLE_FIFO_OVF_CNT_EN
        check("ovf_cnt", 32'(o_ovf_cnt), 32'(ovf_cnt_m));
`endif
        if (exp_q.size() != 0) check("data", 32'(o_data), 32'(exp_q[0]));
        full_m = (exp_q.size() == DEPTH);
        pop    = (exp_q.size() != 0) && rdy;
        drop   = wr && full_m && !pop;
        if (pop) void'(exp_q.pop_front());
        if (wr && !drop) exp_q.push_back(pend_d[LAT-1]);
        if (drop) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (drop) ovf_cnt_m = clr ? 1 : ((ovf_cnt_m == 65535) ? ovf_cnt_m : ovf_cnt_m + 1);
        else if (clr) ovf_cnt_m = 0;
        for (int i = LAT - 1; i > 0; i--) begin
            pend_en[i] = pend_en[i-1];
            pend_d[i]  = pend_d[i-1];
        end
        pend_en[0] = en;
        pend_d[0]  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        i_srst    = 1'b0;
        i_en      = 1'b0;
        i_data    = '0;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        clear_model();
        @(negedge clk);
        do_reset();

        // single sample: strobe at cycle 0, visible at cycle 5
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        idle(LAT, 1'b0);
        check("lat_valid", 32'(o_valid), 32'd1);
        check("lat_data", 32'(o_data), 32'h12 ^ 32'h12 ^ 32'hAA);
        check("lat_count", 32'(o_count), 32'd1);
        idle(2, 1'b1);

        // fill to 16, drop the 17th (clear coincides with the drop: set wins)
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        idle(LAT - 1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("fill_full", 32'(o_full), 32'd1);
        check("fill_count", 32'(o_count), 32'd16);
        check("fill_ovf", 32'(o_overflow), 32'd1);
        check("fill_head", 32'(o_data), 32'd0);
        idle(DEPTH + 1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", 32'(o_overflow), 32'd0);

        // write while full with a pop on the same edge
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i + 32), 1'b0, 1'b0);
        idle(LAT, 1'b0);
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        idle(LAT - 1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("fullpop_count", 32'(o_count), 32'd16);
        check("fullpop_ovf", 32'(o_overflow), 32'd0);
        idle(DEPTH - 1, 1'b1);
        check("fullpop_last", 32'(o_data), 32'h80);
        idle(2, 1'b1);

        // 40-sample stream with the consumer always ready
        for (int i = 0; i < 40; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        idle(LAT + 2, 1'b1);
        check("stream_empty", 32'(o_empty), 32'd1);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0));
        idle(DEPTH + LAT + 2, 1'b1);

        // reset with 5 stored and 3 strobes in flight
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 100), 1'b0, 1'b0);
        idle(LAT, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 200), 1'b0, 1'b0);
        check("pre_rst_count", 32'(o_count), 32'd5);
        do_reset();
        idle(LAT + 2, 1'b0);
        check("post_rst_count", 32'(o_count), 32'd0);
        check("post_rst_valid", 32'(o_valid), 32'd0);

`ifdef FIR_SAMPLE_FIFO_OVF_CNT_EN
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        idle(LAT, 1'b0);
        check("cnt_three", 32'(o_ovf_cnt), 32'd3);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("cnt_clr", 32'(o_ovf_cnt), 32'd0);
        check("cnt_clr_ovf", 32'(o_overflow), 32'd0);
        idle(DEPTH + 1, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
